gray_seq_gen: RTL and testbench

GRAY_SEQ_GEN -- requirements
Module: gray_seq_gen

---
 rtl/gray_seq_gen.sv | 101 ++++++++++
 tb/tb_gray_seq_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_gen.sv
// Gray-code sequence generator: on start, walks a full 2^WIDTH Gray cycle with valid/ready handshake.
// Optional GRAY_BIN_OUT_EN exposes the binary count as bin_out for checking a downstream converter.
module gray_seq_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic             ready,
  output logic [WIDTH-1:0] gray_out,
  output logic             valid,
  output logic             last,
  output logic             busy
`ifdef GRAY_BIN_OUT_EN
  ,
  output logic [WIDTH-1:0] bin_out
`endif
);

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic             dir_q;
  logic [WIDTH-1:0] bcnt_q;
  logic [WIDTH-1:0] gray_q;
  logic             valid_q;
  logic             last_q;
  logic             busy_q;

  logic [WIDTH-1:0] step_d;
  logic [WIDTH-1:0] final_d;
  logic [WIDTH-1:0] init_d;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Next count in the latched direction, and the value at which the run ends.
  always_comb begin
    step_d  = dir_q ? (bcnt_q - ONE) : (bcnt_q + ONE);
    final_d = dir_q ? '0 : MAXV;
    init_d  = dir ? MAXV : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      bcnt_q  <= '0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            dir_q   <= dir;
            bcnt_q  <= init_d;
            gray_q  <= to_gray(init_d);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            // WIDTH >= 2, so the first code is never the final one.
            last_q  <= 1'b0;
          end
        end
        RUN: begin
          if (ready) begin
            if (last_q) begin
              // Final code taken: count and code stay put, no wrap.
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              bcnt_q <= step_d;
              gray_q <= to_gray(step_d);
              last_q <= (step_d == final_d);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gray_out = gray_q;
  assign valid    = valid_q;
  assign last     = last_q;
  assign busy     = busy_q;

`ifdef GRAY_BIN_OUT_EN
  assign bin_out = bcnt_q;
`endif

endmodule

// File: tb/tb_gray_seq_gen.sv
// Bench for gray_seq_gen: directed + random runs against an index-based sequence model.
module tb_gray_seq_gen;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] gray_out;
  logic         valid;
  logic         last;
  logic         busy;
`ifdef GRAY_BIN_OUT_EN
  logic [W-1:0] bin_out;
`endif

  always #5 clk = ~clk;

  gray_seq_gen #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dir      (dir),
    .ready    (ready),
    .gray_out (gray_out),
    .valid    (valid),
    .last     (last),
    .busy     (busy)
`ifdef GRAY_BIN_OUT_EN
    ,
    .bin_out  (bin_out)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: a run is "emit code number k of N"; code is derived from k arithmetically.
  bit mrun  = 1'b0;
  bit mdir  = 1'b0;
  int mk    = 0;
  int mgray = 0;
  int xfers = 0;

  int asc_tab[16]  = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
  int desc_tab[16] = '{8, 9, 11, 10, 14, 15, 13, 12, 4, 5, 7, 6, 2, 3, 1, 0};

  function automatic int idx_of(int k, bit d);
    return d ? (N - 1 - k) : k;
  endfunction

  function automatic int gray_of(int b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] g2b(logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".valid"}, 32'(valid), 32'(mrun));
    chk({tag, ".busy"},  32'(busy),  32'(mrun));
    chk({tag, ".last"},  32'(last),  32'(mrun && (mk == N - 1)));
    chk({tag, ".gray"},  32'(gray_out), 32'(mgray));
`ifdef GRAY_BIN_OUT_EN
    if (mrun) begin
      chk({tag, ".bin"},  32'(bin_out), 32'(idx_of(mk, mdir)));
      chk({tag, ".conv"}, 32'(g2b(gray_out)), 32'(bin_out));
    end
`endif
  endtask

  // One clock: drive, take the edge, advance the model from what the DUT saw, then check.
  task automatic cyc(bit s, bit d, bit r);
    start = s;
    dir   = d;
    ready = r;
    if (valid && r) xfers++;
    @(posedge clk);
    if (!mrun) begin
      if (s) begin
        mrun  = 1'b1;
        mdir  = d;
        mk    = 0;
        mgray = gray_of(idx_of(0, d));
        xfers = 0;
      end
    end else if (r) begin
      if (mk == N - 1) mrun = 1'b0;
      else begin
        mk++;
        mgray = gray_of(idx_of(mk, mdir));
      end
    end
    #1;
    check_all("cyc");
  endtask

  task automatic model_reset();
    mrun  = 1'b0;
    mdir  = 1'b0;
    mk    = 0;
    mgray = 0;
  endtask

  initial begin
    int guard;
    // Reset state
    #2;
    check_all("reset");
`ifdef GRAY_BIN_OUT_EN
    chk("reset.bin", 32'(bin_out), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Ascending, ready always high, compared to the published table
    cyc(1'b1, 1'b0, 1'b1);
    chk("asc.tab0", 32'(gray_out), 32'(asc_tab[0]));
    for (int i = 1; i < N; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk($sformatf("asc.tab%0d", i), 32'(gray_out), 32'(asc_tab[i]));
    end
    cyc(1'b0, 1'b0, 1'b1);
    chk("asc.busy_after", 32'(busy), 32'd0);
    chk("asc.xfers", 32'(xfers), 32'(N));

    // Start in the cycle right after the final transfer; descending with start/dir noise
    cyc(1'b1, 1'b1, 1'b1);
    chk("desc.tab0", 32'(gray_out), 32'(desc_tab[0]));
    for (int i = 1; i < N; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      chk($sformatf("desc.tab%0d", i), 32'(gray_out), 32'(desc_tab[i]));
    end
    cyc(1'b0, 1'b0, 1'b1);
    chk("desc.xfers", 32'(xfers), 32'(N));

    // Stall while gray_out == 2
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      chk("stall.gray", 32'(gray_out), 32'd2);
      chk("stall.valid", 32'(valid), 32'd1);
    end
    cyc(1'b0, 1'b0, 1'b1);
    chk("stall.resume", 32'(gray_out), 32'd6);
    guard = 0;
    while (mrun && guard < 100) begin
      cyc(1'b0, 1'b0, 1'b1);
      guard++;
    end
    chk("stall.done", 32'(mrun), 32'd0);
    chk("stall.xfers", 32'(xfers), 32'(N));

    // Random runs: random direction, random backpressure, noise on start/dir
    for (int r = 0; r < 4; r++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      guard = 0;
      while (mrun && guard < 400) begin
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
        guard++;
      end
      chk("rand.done", 32'(mrun), 32'd0);
      chk("rand.xfers", 32'(xfers), 32'(N));
      cyc(1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-run at gray 7
    cyc(1'b1, 1'b0, 1'b1);
    guard = 0;
    while (mgray != 7 && guard < 40) begin
      cyc(1'b0, 1'b0, 1'b1);
      guard++;
    end
    chk("rst.pre_gray", 32'(gray_out), 32'd7);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst.async");
`ifdef GRAY_BIN_OUT_EN
    chk("rst.bin", 32'(bin_out), 32'd0);
`endif
    #3;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    chk("rst.restart", 32'(gray_out), 32'd0);
    chk("rst.restart_valid", 32'(valid), 32'd1);
    guard = 0;
    while (mrun && guard < 100) begin
      cyc(1'b0, 1'b1, 1'b1);
      guard++;
    end
    chk("rst.done", 32'(mrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
